compare_seq: RTL and testbench

Multi-cycle wide-operand comparator controller. It time-shares one 16-bit compare_16bit instance to compare two WIDTH-bit operands, walking 16-bit chunks from the most-significant end and stopping at the first unequal chunk. It serves datapath users that need wide signed or unsigned magnitude compares (e.g. multi-word compare/branch helpers) without replicating comparators. Requests and responses use a valid/ready handshake.

---
 rtl/compare_seq.sv | 151 +++++++++++++++
 tb/tb_compare_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/compare_seq.sv
// Multi-cycle wide-operand comparator: walks 16-bit chunks MS-first through one shared
// 16-bit comparator and stops at the first unequal chunk. Valid/ready request and response.

module compare_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        equal_o,
  output logic        alarger_o,
  output logic        blarger_o
);

  assign equal_o   = (a_i == b_i);
  assign alarger_o = (a_i > b_i);
  assign blarger_o = (a_i < b_i);

endmodule

module compare_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             equal_o,
  output logic             alarger_o,
  output logic             blarger_o,
  output logic             busy_o
);

  localparam int unsigned NCHUNK = WIDTH / 16;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(NCHUNK - 1);

  if ((WIDTH % 16) != 0 || WIDTH < 16 || WIDTH > 256) begin : g_bad_width
    $error("compare_seq: WIDTH must be a multiple of 16 in the range 16..256");
  end

  typedef enum logic [1:0] {StIdle, StCmp, StResp} state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [NCHUNK-1:0][15:0]  a_q, a_d;
  logic [NCHUNK-1:0][15:0]  b_q, b_d;
  logic                     signed_q, signed_d;
  logic                     equal_q, equal_d;
  logic                     alarger_q, alarger_d;
  logic                     blarger_q, blarger_d;

  logic        flip_msb;
  logic [15:0] chunk_a, chunk_b;
  logic        cmp_eq, cmp_agt, cmp_bgt;

  // Offset-binary trick: flipping the sign bit of the top chunk turns a signed compare
  // into an unsigned one; lower chunks carry pure magnitude.
  assign flip_msb = signed_q && (idx_q == IdxTop);
  assign chunk_a  = a_q[idx_q] ^ {flip_msb, 15'b0};
  assign chunk_b  = b_q[idx_q] ^ {flip_msb, 15'b0};

  compare_16bit u_cmp (
    .a_i       (chunk_a),
    .b_i       (chunk_b),
    .equal_o   (cmp_eq),
    .alarger_o (cmp_agt),
    .blarger_o (cmp_bgt)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    signed_d  = signed_q;
    equal_d   = equal_q;
    alarger_d = alarger_q;
    blarger_d = blarger_q;

    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            a_d      = a_i;
            b_d      = b_i;
            signed_d = signed_i;
            idx_d    = IdxTop;
            state_d  = StCmp;
          end
        end
        StCmp: begin
          if (!cmp_eq) begin
            equal_d   = 1'b0;
            alarger_d = cmp_agt;
            blarger_d = cmp_bgt;
            state_d   = StResp;
          end else if (idx_q == '0) begin
            equal_d   = 1'b1;
            alarger_d = 1'b0;
            blarger_d = 1'b0;
            state_d   = StResp;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      equal_q   <= 1'b0;
      alarger_q <= 1'b0;
      blarger_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      signed_q  <= signed_d;
      equal_q   <= equal_d;
      alarger_q <= alarger_d;
      blarger_q <= blarger_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign equal_o     = equal_q;
  assign alarger_o   = alarger_q;
  assign blarger_o   = blarger_q;

endmodule

// File: tb/tb_compare_seq.sv
// Directed bench for compare_seq (WIDTH=64): vector table plus hand sequences for
// backpressure, flush and asynchronous reset.

module tb_compare_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic        signed_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        equal_o;
  logic        alarger_o;
  logic        blarger_o;
  logic        busy_o;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  compare_seq #(.WIDTH(64)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .signed_i    (signed_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .equal_o     (equal_o),
    .alarger_o   (alarger_o),
    .blarger_o   (blarger_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sgn;
    logic        chg;  // scramble operands right after acceptance
    logic        eq;
    logic        al;
    logic        bl;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called one step after an edge; returns cycles until rsp_valid_o, or -1 on timeout.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk_i);
      #1;
      if (rsp_valid_o) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    req_valid_i = 1'b1;
    a_i         = v.a;
    b_i         = v.b;
    signed_i    = v.sgn;
    check({tag, " req_ready"}, 64'(req_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    if (v.chg) begin
      a_i      = ~v.a;
      b_i      = 64'h0;
      signed_i = ~v.sgn;
    end
    wait_rsp(lat);
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    check({tag, " result"}, {61'd0, equal_o, alarger_o, blarger_o}, {61'd0, v.eq, v.al, v.bl});
    @(posedge clk_i);
    #1;
    check({tag, " rsp_drop"}, {62'd0, rsp_valid_o, busy_o}, 64'd0);
  endtask

  initial begin
    int lat;
    logic seen;

    vecs[0]  = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vecs[1]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[3]  = '{64'hFFFF_FFFF_FFFF_0001, 64'hFFFF_FFFF_FFFF_0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4};
    vecs[4]  = '{64'hFFFF_FFFF_FFFF_0001, 64'hFFFF_FFFF_FFFF_0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4};
    vecs[5]  = '{64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[9]  = '{64'h1234_5678_0000_FFFF, 64'h1234_5678_0001_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[10] = '{64'h7FFF_0000_0000_0000, 64'h0001_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};

    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    a_i         = '0;
    b_i         = '0;
    signed_i    = 1'b0;
    rsp_ready_i = 1'b1;
    #12;
    check("reset outputs",
          {58'd0, req_ready_o, rsp_valid_o, busy_o, equal_o, alarger_o, blarger_o},
          64'b100000);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold the response while a second request knocks.
    rsp_ready_i = 1'b0;
    run_vec_hold: begin
      req_valid_i = 1'b1;
      a_i         = 64'h0000_0000_0000_0005;
      b_i         = 64'h0000_0000_0000_0003;
      signed_i    = 1'b0;
      @(posedge clk_i);
      #1;
      a_i = 64'h1000_0000_0000_0000;
      b_i = 64'h2000_0000_0000_0000;
      wait_rsp(lat);
      check("bp latency", 64'(lat), 64'd4);
      for (int c = 0; c < 5; c++) begin
        check($sformatf("bp hold%0d", c),
              {59'd0, rsp_valid_o, req_ready_o, equal_o, alarger_o, blarger_o},
              64'b10010);
        @(posedge clk_i);
        #1;
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("bp release", {62'd0, rsp_valid_o, req_ready_o}, 64'b01);
      @(posedge clk_i);
      #1;
      check("bp b2b accept", 64'(busy_o), 64'd1);
      req_valid_i = 1'b0;
      wait_rsp(lat);
      check("bp b2b latency", 64'(lat), 64'd1);
      check("bp b2b result", {61'd0, equal_o, alarger_o, blarger_o}, 64'b001);
      @(posedge clk_i);
      #1;
    end

    // Flush in the second CMP cycle of an equal compare.
    req_valid_i = 1'b1;
    a_i         = 64'hDEAD_BEEF_0000_1111;
    b_i         = 64'hDEAD_BEEF_0000_1111;
    signed_i    = 1'b0;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    check("flush idle", {61'd0, busy_o, rsp_valid_o, req_ready_o}, 64'b001);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i);
      #1;
      seen |= rsp_valid_o;
    end
    check("flush no rsp", 64'(seen), 64'd0);

    // Request presented alongside flush is dropped.
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    check("flush blocks accept", 64'(busy_o), 64'd0);

    run_vec(vecs[5], "post-flush");

    // Asynchronous reset between edges while a response is held.
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    a_i         = 64'h9000_0000_0000_0000;
    b_i         = 64'h1000_0000_0000_0000;
    signed_i    = 1'b0;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    wait_rsp(lat);
    check("rst pre result", {60'd0, rsp_valid_o, equal_o, alarger_o, blarger_o}, 64'b1010);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst mid-resp",
          {58'd0, req_ready_o, rsp_valid_o, busy_o, equal_o, alarger_o, blarger_o},
          64'b100000);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    run_vec(vecs[0], "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
